sdram_wb_arbiter: RTL and testbench

//  Shares the single pipelined-Wishbone slave port of the SDRAM controller among NMASTERS bus masters
//  (CPU, video fetch, DMA). Round-robin grant per bus cycle (CYC); the owner's requests are forwarded

---
 rtl/sdram_arb_pkg.sv | 16 +
 rtl/sdram_rr_pick.sv | 32 +++
 rtl/sdram_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM Wishbone arbiter.
//   state_t        : arbiter FSM states
//   onehot_to_idx  : one-hot (up to 8 bits) to binary index
package sdram_arb_pkg;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++)
         if (oh[i]) idx = idx | 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   in  N    request vector
//   last  in  IW   index of previous winner (lowest priority)
//   valid out 1    any request present
//   idx   out IW   winner: first set bit searching last+1 upward with wrap
module sdram_rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
)(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [N-1:0] oh;

   // Walk from the farthest candidate back to the nearest so the nearest
   // requester after 'last' overwrites everything else.
   always_comb begin
      oh = '0;
      for (int k = N; k >= 1; k--)
         if (req[(int'(last) + k) % N]) oh = N'(1) << ((int'(last) + k) % N);
   end

   assign valid = |req;
   assign idx   = IW'(onehot_to_idx(8'(oh)));

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave (SDRAM controller)
// among NMASTERS masters. Grant is held for a whole CYC tenure and never moves
// while the controller still owes ACKs (DRAIN absorbs them).
// Ports:
//   clk_i, rst_i (sync, active-high)
//   m_cyc_i/m_stb_i/m_we_i [NMASTERS], m_adr_i/m_sel_i/m_dat_i packed per master
//   m_dat_o (broadcast), m_ack_o (owner only), m_stall_o (1 for non-owners)
//   s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_sel_o/s_dat_o to controller,
//   s_dat_i/s_ack_i/s_stall_i from controller
//   gnt_o  one-hot owner while in GRANT, registered
// Config macro: SDRAM_ARB_QUOTA_EN enables forced rotation after QUOTA accepts
// when another master is waiting.
module sdram_wb_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NMASTERS = 4,
   parameter int AWIDTH   = 26,
   parameter int DWIDTH   = 32,
   parameter int MAXOUT   = 15,
   parameter int QUOTA    = 16
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NMASTERS-1:0]          m_cyc_i,
   input  logic [NMASTERS-1:0]          m_stb_i,
   input  logic [NMASTERS-1:0]          m_we_i,
   input  logic [NMASTERS*AWIDTH-1:0]   m_adr_i,
   input  logic [NMASTERS*DWIDTH/8-1:0] m_sel_i,
   input  logic [NMASTERS*DWIDTH-1:0]   m_dat_i,
   output logic [DWIDTH-1:0]            m_dat_o,
   output logic [NMASTERS-1:0]          m_ack_o,
   output logic [NMASTERS-1:0]          m_stall_o,
   output logic                         s_cyc_o,
   output logic                         s_stb_o,
   output logic                         s_we_o,
   output logic [AWIDTH-1:0]            s_adr_o,
   output logic [DWIDTH/8-1:0]          s_sel_o,
   output logic [DWIDTH-1:0]            s_dat_o,
   input  logic [DWIDTH-1:0]            s_dat_i,
   input  logic                         s_ack_i,
   input  logic                         s_stall_i,
   output logic [NMASTERS-1:0]          gnt_o
);

   localparam int IW = $clog2(NMASTERS);
   localparam int CW = $clog2(MAXOUT + 1);
   localparam int SW = DWIDTH / 8;
   localparam logic [CW-1:0] MAXC = CW'(MAXOUT);

   if (NMASTERS < 2 || NMASTERS > 8 || QUOTA < 1) begin : g_bad_cfg
      $error("sdram_wb_arbiter: NMASTERS must be 2..8 and QUOTA >= 1");
   end

   state_t              state, state_n;
   logic [IW-1:0]       owner, owner_n, last, last_n, pick_idx;
   logic                pick_vld;
   logic [CW-1:0]       out_cnt, cnt_n, cnt_upd;
   logic [NMASTERS-1:0] own_oh, gnt_q;
   logic                hold, stb_g, accept, dec;

   sdram_rr_pick #(.N(NMASTERS), .IW(IW)) u_pick (
      .req   (m_cyc_i),
      .last  (last),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   assign own_oh = NMASTERS'(1) << owner;

   // Owner's request path, forwarded unmodified.
   assign s_we_o  = m_we_i[owner];
   assign s_adr_o = m_adr_i[owner*AWIDTH +: AWIDTH];
   assign s_sel_o = m_sel_i[owner*SW +: SW];
   assign s_dat_o = m_dat_i[owner*DWIDTH +: DWIDTH];
   assign m_dat_o = s_dat_i;
   assign gnt_o   = gnt_q;

   assign stb_g  = (state == S_GRANT) & m_stb_i[owner] & (out_cnt < MAXC) & ~hold;
   assign accept = stb_g & ~s_stall_i;
   // An ACK with nothing outstanding is still forwarded but must not underflow.
   assign dec    = s_ack_i & (out_cnt != '0);

   always_comb begin
      cnt_upd = out_cnt;
      if (accept & ~dec)      cnt_upd = out_cnt + 1'b1;
      else if (~accept & dec) cnt_upd = out_cnt - 1'b1;
   end

`ifdef SDRAM_ARB_QUOTA_EN
   localparam int QW = $clog2(QUOTA + 1);
   localparam logic [QW-1:0] QC = QW'(QUOTA);
   logic [QW-1:0] quota_cnt;

   // Counts accepts in the current tenure; cleared whenever not granted.
   always_ff @(posedge clk_i) begin
      if (rst_i || state != S_GRANT)     quota_cnt <= '0;
      else if (accept && quota_cnt < QC) quota_cnt <= quota_cnt + 1'b1;
   end

   // Quota used up and someone else waiting: stop issuing, let ACKs drain.
   assign hold = (quota_cnt == QC) && (|(m_cyc_i & ~own_oh));
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      owner_n   = owner;
      last_n    = last;
      cnt_n     = out_cnt;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      m_ack_o   = '0;
      m_stall_o = '1;
      case (state)
         S_IDLE: begin
            cnt_n = '0;   // stray ACKs are dropped here
            if (pick_vld) begin
               owner_n = pick_idx;
               state_n = S_GRANT;
            end
         end
         S_GRANT: begin
            s_cyc_o          = 1'b1;
            s_stb_o          = stb_g;
            m_stall_o[owner] = s_stall_i | (out_cnt == MAXC) | hold;
            m_ack_o          = s_ack_i ? own_oh : '0;
            cnt_n            = cnt_upd;
            if (!m_cyc_i[owner]) begin
               if (out_cnt == '0 || (out_cnt == CW'(1) && s_ack_i)) begin
                  state_n = S_IDLE;
                  last_n  = owner;
               end else begin
                  state_n = S_DRAIN;
               end
            end else if (hold && out_cnt == '0) begin
               // Preempted owner keeps CYC and re-competes at lowest priority.
               state_n = S_IDLE;
               last_n  = owner;
            end
         end
         S_DRAIN: begin
            s_cyc_o = 1'b1;
            cnt_n   = cnt_upd;
            if (cnt_upd == '0) begin
               state_n = S_IDLE;
               last_n  = owner;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         owner   <= '0;
         last    <= IW'(NMASTERS - 1);
         out_cnt <= '0;
         gnt_q   <= '0;
      end else begin
         state   <= state_n;
         owner   <= owner_n;
         last    <= last_n;
         out_cnt <= cnt_n;
         gnt_q   <= (state_n == S_GRANT) ? (NMASTERS'(1) << owner_n) : '0;
      end
   end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed self-checking bench for sdram_wb_arbiter (default parameters).
// Inputs change 1 ns after the rising edge, outputs are sampled 2 ns later.
module tb_sdram_wb_arbiter;
   localparam int N = 4, AW = 26, DW = 32;

   logic            clk = 1'b0, rst = 1'b1;
   logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
   logic [N*AW-1:0] m_adr = '0;
   logic [N*DW/8-1:0] m_sel = '0;
   logic [N*DW-1:0] m_dat = '0;
   logic [DW-1:0]   m_dat_o, s_dat = '0, s_dat_o;
   logic [N-1:0]    m_ack_o, m_stall_o, gnt_o;
   logic            s_cyc_o, s_stb_o, s_we_o, s_ack = 1'b0, s_stall = 1'b0;
   logic [AW-1:0]   s_adr_o;
   logic [DW/8-1:0] s_sel_o;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   sdram_wb_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_sel_i(m_sel), .m_dat_i(m_dat),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_stall_o(m_stall_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_stall_i(s_stall),
      .gnt_o(gnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic do_reset;
      rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_stall = 1'b0;
      step;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc, acks;
      step; step;
      settle;
      chk("rst_gnt",   gnt_o, 0);
      chk("rst_scyc",  s_cyc_o, 0);
      chk("rst_sstb",  s_stb_o, 0);
      chk("rst_stall", m_stall_o, 4'hF);
      chk("rst_ack",   m_ack_o, 0);
      rst = 1'b0;

      // 1: M0 single read, ACK three cycles after accept
      m_cyc[0] = 1; m_stb[0] = 1; m_adr[0*AW +: AW] = 26'h0000100;
      settle;
      chk("t1_idle_scyc",  s_cyc_o, 0);
      chk("t1_idle_stall", m_stall_o, 4'hF);
      step; settle;
      chk("t1_gnt",   gnt_o, 4'b0001);
      chk("t1_sstb",  s_stb_o, 1);
      chk("t1_adr",   s_adr_o, 26'h0000100);
      chk("t1_stall", m_stall_o, 4'b1110);
      step; m_stb[0] = 0; settle;
      chk("t1_stb_off", s_stb_o, 0);
      step;
      step; s_ack = 1; s_dat = 32'hCAFE0001; settle;
      chk("t1_ack", m_ack_o, 4'b0001);
      chk("t1_dat", m_dat_o, 32'hCAFE0001);
      step; s_ack = 0; m_cyc[0] = 0; settle;
      chk("t1_noack", m_ack_o, 0);
      step; settle;
      chk("t1_idle_gnt",  gnt_o, 0);
      chk("t1_idle_scyc2", s_cyc_o, 0);

      // 2: M0 and M2 together from reset
      do_reset;
      m_cyc = 4'b0101; settle;
      step; settle;
      chk("t2_gnt_m0", gnt_o, 4'b0001);
      step; m_cyc[0] = 0; settle;
      step; settle;
      chk("t2_idle_gap", gnt_o, 0);
      step; settle;
      chk("t2_gnt_m2", gnt_o, 4'b0100);
      chk("t2_scyc",   s_cyc_o, 1);
      m_cyc = '0;
      step;

      // 3: M1 four pipelined writes, stall held two cycles mid-burst
      m_cyc[1] = 1; m_we[1] = 1; m_stb[1] = 1;
      m_dat[1*DW +: DW] = 32'h1234_5678; m_sel[1*4 +: 4] = 4'b1010;
      settle;
      step;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         logic st;
         st = (i == 2 || i == 3);
         s_stall = st;
         m_adr[1*AW +: AW] = 26'h200 + 26'(acc);
         settle;
         chk("t3_sstb",  s_stb_o, 1);
         chk("t3_adr",   s_adr_o, 26'h200 + 26'(acc));
         chk("t3_stall", m_stall_o, st ? 4'hF : 4'b1101);
         if (s_stb_o && !s_stall) acc++;
         step;
      end
      chk("t3_accepts", acc, 4);
      chk("t3_we",  s_we_o, 1);
      chk("t3_sel", s_sel_o, 4'b1010);
      chk("t3_dat", s_dat_o, 32'h1234_5678);
      m_stb[1] = 0; s_stall = 0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         s_ack = 1; settle;
         chk("t3_ack", m_ack_o, 4'b0010);
         if (m_ack_o[1]) acks++;
         step;
      end
      chk("t3_acks", acks, 4);
      s_ack = 0; m_cyc[1] = 0; m_we[1] = 0;
      step;

      // 4: M3 leaves with two reads outstanding -> DRAIN, then M0
      m_cyc = 4'b1001; m_stb[3] = 1; settle;
      step; settle;
      chk("t4_gnt_m3", gnt_o, 4'b1000);
      chk("t4_sstb",   s_stb_o, 1);
      step;
      step; m_stb[3] = 0; m_cyc[3] = 0; settle;
      step; settle;
      chk("t4_drain_scyc",  s_cyc_o, 1);
      chk("t4_drain_sstb",  s_stb_o, 0);
      chk("t4_drain_stall", m_stall_o, 4'hF);
      chk("t4_drain_gnt",   gnt_o, 0);
      s_ack = 1; settle;
      chk("t4_absorb1", m_ack_o, 0);
      step; settle;
      chk("t4_absorb2", m_ack_o, 0);
      step; s_ack = 0; settle;
      chk("t4_idle_scyc", s_cyc_o, 0);
      step; settle;
      chk("t4_gnt_m0", gnt_o, 4'b0001);
      m_cyc = '0;
      step;

      // 5: outstanding limit, ACKs withheld
      m_cyc[0] = 1; m_stb[0] = 1; settle;
      step;
      acc = 0;
      for (int i = 0; i < 15; i++) begin
         settle;
         if (s_stb_o && !s_stall) acc++;
         step;
      end
      chk("t5_accepts", acc, 15);
      settle;
      chk("t5_16th_sstb",  s_stb_o, 0);
      chk("t5_16th_stall", m_stall_o, 4'hF);
      step; s_ack = 1; settle;
      chk("t5_ack", m_ack_o, 4'b0001);
      step; s_ack = 0; settle;
      chk("t5_release_sstb",  s_stb_o, 1);
      chk("t5_release_stall", m_stall_o, 4'b1110);
      step; m_stb[0] = 0; m_cyc[0] = 0; settle;
      step;
      for (int i = 0; i < 15; i++) begin
         s_ack = 1; settle;
         if (i == 14) chk("t5_still_drain", s_cyc_o, 1);
         step;
      end
      s_ack = 0; settle;
      chk("t5_drained_scyc", s_cyc_o, 0);
      chk("t5_drained_gnt",  gnt_o, 0);

`ifdef SDRAM_ARB_QUOTA_EN
      // 6: quota forces rotation from M0 to waiting M1
      do_reset;
      m_cyc = 4'b0011; m_stb[0] = 1; settle;
      step;
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         s_ack = (i > 0); settle;
         if (s_stb_o && !s_stall) acc++;
         step;
      end
      chk("t6_accepts", acc, 16);
      s_ack = 1; settle;
      chk("t6_hold_sstb",  s_stb_o, 0);
      chk("t6_hold_stall", m_stall_o, 4'hF);
      step; s_ack = 0; settle;
      chk("t6_still_m0", gnt_o, 4'b0001);
      step; settle;
      chk("t6_idle", gnt_o, 0);
      step; settle;
      chk("t6_gnt_m1", gnt_o, 4'b0010);
      m_cyc = '0; m_stb = '0;
      step;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
